pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL take parameter REG_W, default 5, register-address width.
REQ-002 SHALL take parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have ports: clk input 1, sole clock, all state on rising edge.
REQ-004 SHALL have ports: rst input 1, reset, asynchronous and active-high.
REQ-005 SHALL have ports: dec_valid input 1, decode-stage instruction present.
REQ-006 SHALL have ports: dec_rd input REG_W, destination register; dec_ra input REG_W, source A; dec_rb input REG_W, source B.
REQ-007 SHALL have ports: dec_use_rb input 1, instruction reads source B (register operand or store data).
REQ-008 SHALL have ports: dec_wb input 1, instruction writes the register file; dec_ld input 1, instruction is a memory load.
REQ-009 SHALL have ports: pc_hold output 1, freeze PC and instruction register; id_bubble output 1, zero the control word entering ctrl stage 1.
REQ-010 SHALL have ports: fwd_a_sel output 2, fwd_b_sel output 2, EX operand source (00 RF, 01 EX/MEM result, 10 MEM/WB value, 11 last-writeback latch).
REQ-011 SHALL have ports: stall_cnt output CNT_W, total bubbles inserted.

Function
REQ-012 SHALL track three in-flight slots s1 (EX), s2 (MEM), s3 (WB), each {valid, wb, ld, rd}.
REQ-013 SHALL shift s1->s2->s3 every cycle unconditionally; s1 loads the decode fields when no stall, otherwise an invalid entry (bubble).
REQ-014 SHALL match a slot only if valid=1, wb=1 and rd equals the source; source B compared only when dec_use_rb=1.
REQ-015 SHALL leave the ID instruction held (pc_hold=1) across consecutive stall cycles until no hazard remains, re-evaluating each cycle against shifted slots.
REQ-016 SHALL drive pc_hold and id_bubble combinationally and identically in the hazard cycle; both 0 when dec_valid=0.
REQ-017 SHALL treat every register address as real: no hardwired-zero exemption.
REQ-018 SHALL increment stall_cnt by 1 per stall cycle, saturating at all-ones (no wrap).
REQ-019 SHALL evaluate hazards identically for an instruction sourcing the same register on A and B (single stall, not double).

Reset
REQ-020 SHALL, on rst assertion, clear all slots to invalid immediately, even mid-stall.
REQ-021 SHALL reset pc_hold=0, id_bubble=0, fwd_a_sel=fwd_b_sel=00, stall_cnt=0.
REQ-022 SHALL resume normal tracking on the first clk edge after rst deasserts.

Configuration
REQ-023 SHALL compile forwarding in or out with macro PIPE_FWD_EN.
REQ-024 SHALL, without PIPE_FWD_EN, stall on any match in s1, s2 or s3 (dependent back-to-back pair costs 3 bubbles); fwd_*_sel held at 00.
REQ-025 SHALL, with PIPE_FWD_EN, stall only when the s1 match has ld=1 (load-use, 1 bubble).
REQ-026 SHALL, with PIPE_FWD_EN, register fwd_*_sel on the non-stall decode edge so it is valid during the consumer's EX cycle: s1 match->01, s2->10, s3->11, none->00.
REQ-027 SHALL prioritise youngest match s1 > s2 > s3 for forwarding selection.

Structure
REQ-028 SHALL place the fwd-select encodings and the slot-record typedef in shared package cpu_pkg.
REQ-029 SHALL implement the three-slot tracker as one sub-module, hazard_scoreboard; comparison and stall logic stay in the top.

Verification
REQ-030 SHALL cover: ADD r3 then ADD r4,r3,r1, no fwd -> 3 cycles pc_hold=1, stall_cnt=3, consumer enters s1 on 4th cycle.
REQ-031 SHALL cover: same pair with PIPE_FWD_EN -> no stall, fwd_a_sel=01 in consumer EX cycle.
REQ-032 SHALL cover: LOAD r5 then SUB r6,r2,r5, PIPE_FWD_EN -> 1 bubble, then fwd_b_sel=10.
REQ-033 SHALL cover: producer r7, two independent instructions, consumer of r7, PIPE_FWD_EN -> fwd_a_sel=11; without -> 1 stall cycle.
REQ-034 SHALL cover: store with dec_use_rb=1 sourcing r3 after r3 writer -> B compared; immediate op with dec_use_rb=0 on matching rb -> no stall.
REQ-035 SHALL cover: rst asserted mid 3-bubble stall -> pc_hold=0 and all slots invalid same cycle; stall_cnt forced to 0xFFFF then one more stall -> stays 0xFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared slot record, forwarding-select encodings and match helpers
package cpu_pkg;

    // Widest register address a slot can hold; narrower addresses are zero-extended.
    localparam int SLOT_RD_W = 8;

    typedef enum logic [1:0] {
        FWD_RF       = 2'b00,
        FWD_EX_MEM   = 2'b01,
        FWD_MEM_WB   = 2'b10,
        FWD_WB_LATCH = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic                 valid;
        logic                 wb;
        logic                 ld;
        logic [SLOT_RD_W-1:0] rd;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    function automatic logic slot_hit(input slot_t s, input logic [SLOT_RD_W-1:0] src);
        return s.valid && s.wb && (s.rd == src);
    endfunction

    // hit[0] is the youngest slot (EX), so it wins.
    function automatic fwd_sel_t fwd_pick(input logic [2:0] hit);
        if (hit[0]) return FWD_EX_MEM;
        if (hit[1]) return FWD_MEM_WB;
        if (hit[2]) return FWD_WB_LATCH;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode-stage request and hazard-control response bundle
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             dec_valid;
    logic [REG_W-1:0] dec_rd;
    logic [REG_W-1:0] dec_ra;
    logic [REG_W-1:0] dec_rb;
    logic             dec_use_rb;
    logic             dec_wb;
    logic             dec_ld;
    logic             pc_hold;
    logic             id_bubble;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output dec_valid, dec_rd, dec_ra, dec_rb, dec_use_rb, dec_wb, dec_ld,
        input  pc_hold, id_bubble, fwd_a_sel, fwd_b_sel, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_rd, dec_ra, dec_rb, dec_use_rb, dec_wb, dec_ld,
        output pc_hold, id_bubble, fwd_a_sel, fwd_b_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - three-deep EX/MEM/WB in-flight destination tracker
module hazard_scoreboard
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  slot_t s1_next,
    output slot_t s1,
    output slot_t s2,
    output slot_t s3
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= SLOT_EMPTY;
            s2 <= SLOT_EMPTY;
            s3 <= SLOT_EMPTY;
        end else begin
            s1 <= s1_next;
            s2 <= s1;
            s3 <= s2;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - decode-stage RAW hazard stall and forwarding control; PIPE_FWD_EN enables forwarding
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    slot_t                s1, s2, s3;
    slot_t                s1_next;
    logic [REG_W-1:0]     rd_w, ra_w, rb_w;
    logic [SLOT_RD_W-1:0] src_a, src_b;
    logic [2:0]           hit_a, hit_b;
    logic                 stall;
    logic [CNT_W-1:0]     stall_cnt_q;

    assign rd_w  = bus.dec_rd;
    assign ra_w  = bus.dec_ra;
    assign rb_w  = bus.dec_rb;
    assign src_a = SLOT_RD_W'(ra_w);
    assign src_b = SLOT_RD_W'(rb_w);

    assign hit_a = {slot_hit(s3, src_a), slot_hit(s2, src_a), slot_hit(s1, src_a)};
    assign hit_b = {3{bus.dec_use_rb}} &
                   {slot_hit(s3, src_b), slot_hit(s2, src_b), slot_hit(s1, src_b)};

`ifdef PIPE_FWD_EN
    // Only a load still in EX cannot be bypassed in time.
    assign stall = bus.dec_valid && s1.ld && (hit_a[0] || hit_b[0]);
`else
    assign stall = bus.dec_valid && ((|hit_a) || (|hit_b));
`endif

    assign bus.pc_hold   = stall;
    assign bus.id_bubble = stall;

    always_comb begin
        s1_next = SLOT_EMPTY;
        if (bus.dec_valid && !stall) begin
            s1_next.valid = 1'b1;
            s1_next.wb    = bus.dec_wb;
            s1_next.ld    = bus.dec_ld;
            s1_next.rd    = SLOT_RD_W'(rd_w);
        end
    end

    hazard_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .s1_next (s1_next),
        .s1      (s1),
        .s2      (s2),
        .s3      (s3)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;

`ifdef PIPE_FWD_EN
    fwd_sel_t fwd_a_q, fwd_b_q;

    // Captured when the consumer leaves decode, so it is stable during its EX cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (bus.dec_valid && !stall) begin
            fwd_a_q <= fwd_pick(hit_a);
            fwd_b_q <= fwd_pick(hit_b);
        end else begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end
    end

    assign bus.fwd_a_sel = fwd_a_q;
    assign bus.fwd_b_sel = fwd_b_q;

    logic unused_slot_ld;
    assign unused_slot_ld = ^{s2.ld, s3.ld};
`else
    assign bus.fwd_a_sel = FWD_RF;
    assign bus.fwd_b_sel = FWD_RF;

    logic unused_slot_ld;
    assign unused_slot_ld = ^{s1.ld, s2.ld, s3.ld};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl, expectations follow PIPE_FWD_EN
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  stalls;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();

    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    exp_cnt = 0;
    int    acc_cnt = 0;
    int    seen_cnt = 0;
    int    bubble_bad = 0;
    exp_t  exp_q[$];
    int    stall_obs[$];
    string scen = "reset";
    exp_t  mon_e;
    int    mon_n;

    function automatic int st(input int nofwd_val, input int fwd_val);
        return FWD ? fwd_val : nofwd_val;
    endfunction

    function automatic logic [1:0] sel(input logic [1:0] v);
        return FWD ? v : 2'b00;
    endfunction

    // Called just after a falling edge; returns just after the next falling edge
    // following acceptance, which is the instruction's EX cycle.
    task automatic drive_instr(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                               input logic use_rb, input logic wb, input logic ld,
                               input int est, input logic [1:0] efa, input logic [1:0] efb);
        exp_t e;
        int   n;
        exp_cnt  = (exp_cnt + est > 65535) ? 65535 : exp_cnt + est;
        e.stalls = 8'(est);
        e.fa     = efa;
        e.fb     = efb;
        e.cnt    = exp_cnt[15:0];
        exp_q.push_back(e);
        bus.dec_valid  = 1'b1;
        bus.dec_rd     = rd;
        bus.dec_ra     = ra;
        bus.dec_rb     = rb;
        bus.dec_use_rb = use_rb;
        bus.dec_wb     = wb;
        bus.dec_ld     = ld;
        n = 0;
        #1;
        while (bus.pc_hold === 1'b1 && n < 8) begin
            if (bus.id_bubble !== 1'b1) bubble_bad++;
            @(negedge clk);
            #1;
            n++;
        end
        if (bus.id_bubble !== 1'b0) bubble_bad++;
        stall_obs.push_back(n);
        @(posedge clk);
        #1;
        acc_cnt++;
        bus.dec_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.dec_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (seen_cnt != acc_cnt) begin
            seen_cnt = seen_cnt + 1;
            checks = checks + 1;
            if (exp_q.size() == 0 || stall_obs.size() == 0) begin
                errors = errors + 1;
                $display("FAIL %s scoreboard_empty: got accept #%0d required a queued expectation", scen, seen_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = stall_obs.pop_front();
                if (mon_n !== int'(mon_e.stalls)) begin
                    errors = errors + 1;
                    $display("FAIL %s stall_cycles: got %0d required %0d", scen, mon_n, mon_e.stalls);
                end
                checks = checks + 3;
                if (bus.fwd_a_sel !== mon_e.fa) begin
                    errors = errors + 1;
                    $display("FAIL %s fwd_a_sel: got %b required %b", scen, bus.fwd_a_sel, mon_e.fa);
                end
                if (bus.fwd_b_sel !== mon_e.fb) begin
                    errors = errors + 1;
                    $display("FAIL %s fwd_b_sel: got %b required %b", scen, bus.fwd_b_sel, mon_e.fb);
                end
                if (bus.stall_cnt !== mon_e.cnt) begin
                    errors = errors + 1;
                    $display("FAIL %s stall_cnt: got %0d required %0d", scen, bus.stall_cnt, mon_e.cnt);
                end
            end
        end
    end

    task automatic test_reset();
        scen = "reset";
        rst = 1'b1;
        bus.dec_valid = 1'b1; bus.dec_rd = 5'd3; bus.dec_ra = 5'd3; bus.dec_rb = 5'd3;
        bus.dec_use_rb = 1'b1; bus.dec_wb = 1'b1; bus.dec_ld = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks = checks + 5;
        if (bus.pc_hold !== 1'b0) begin errors++; $display("FAIL reset pc_hold: got %b required 0", bus.pc_hold); end
        if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL reset id_bubble: got %b required 0", bus.id_bubble); end
        if (bus.fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset fwd_a_sel: got %b required 00", bus.fwd_a_sel); end
        if (bus.fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset fwd_b_sel: got %b required 00", bus.fwd_b_sel); end
        if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset stall_cnt: got %0d required 0", bus.stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
        bus.dec_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_invalid_decode();
        scen = "invalid_decode";
        drive_instr(5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        bus.dec_valid = 1'b0; bus.dec_ra = 5'd9; bus.dec_rb = 5'd9;
        #1;
        checks = checks + 2;
        if (bus.pc_hold !== 1'b0) begin errors++; $display("FAIL invalid_decode pc_hold: got %b required 0", bus.pc_hold); end
        if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL invalid_decode id_bubble: got %b required 0", bus.id_bubble); end
        @(negedge clk);
        idle(3);
    endtask

    task automatic test_raw_pair();
        scen = "raw_pair";
        drive_instr(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd4, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0, st(3, 0), sel(2'b01), 2'b00);
        idle(4);
    endtask

    task automatic test_load_use();
        scen = "load_use";
        drive_instr(5'd5, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 0, 2'b00, 2'b00);
        drive_instr(5'd6, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, st(3, 1), 2'b00, sel(2'b10));
        idle(4);
    endtask

    task automatic test_wb_distance();
        scen = "wb_distance";
        drive_instr(5'd7,  5'd1,  5'd1,  1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd8,  5'd9,  5'd10, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd11, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd14, 5'd7,  5'd15, 1'b1, 1'b1, 1'b0, st(1, 0), sel(2'b11), 2'b00);
        idle(4);
    endtask

    task automatic test_use_rb();
        scen = "store_rb";
        drive_instr(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd0, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, st(3, 0), 2'b00, sel(2'b01));
        idle(4);
        scen = "imm_ignores_rb";
        drive_instr(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd9, 5'd1, 5'd3, 1'b0, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        idle(4);
        scen = "non_writer";
        drive_instr(5'd20, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd21, 5'd20, 5'd20, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        idle(4);
    endtask

    task automatic test_same_src();
        scen = "same_src_alu";
        drive_instr(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, st(3, 0), sel(2'b01), sel(2'b01));
        idle(4);
        scen = "same_src_load";
        drive_instr(5'd5, 5'd2, 5'd2, 1'b0, 1'b1, 1'b1, 0, 2'b00, 2'b00);
        drive_instr(5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, st(3, 1), sel(2'b10), sel(2'b10));
        idle(4);
    endtask

    task automatic test_reg_zero();
        scen = "reg_zero";
        drive_instr(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, st(3, 0), sel(2'b01), 2'b00);
        idle(4);
    endtask

    task automatic test_back_to_back();
        scen = "priority_s1";
        drive_instr(5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, st(3, 0), sel(2'b01), sel(2'b01));
        drive_instr(5'd9, 5'd8, 5'd1, 1'b1, 1'b1, 1'b0, st(3, 0), sel(2'b01), 2'b00);
        idle(4);
        scen = "priority_s2";
        drive_instr(5'd7,  5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd7,  5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 0, 2'b00, 2'b00);
        drive_instr(5'd11, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0, st(2, 0), sel(2'b10), 2'b00);
        idle(4);
    endtask

    task automatic test_reset_mid_stall();
        scen = "reset_mid_stall";
        drive_instr(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 0, 2'b00, 2'b00);
        bus.dec_valid = 1'b1; bus.dec_rd = 5'd6; bus.dec_ra = 5'd3; bus.dec_rb = 5'd4;
        bus.dec_use_rb = 1'b1; bus.dec_wb = 1'b1; bus.dec_ld = 1'b0;
        #1;
        checks++;
        if (bus.pc_hold !== 1'b1) begin errors++; $display("FAIL reset_mid_stall first_hold: got %b required 1", bus.pc_hold); end
        @(negedge clk);
        #1;
        checks++;
        if (bus.pc_hold !== !FWD) begin errors++; $display("FAIL reset_mid_stall second_hold: got %b required %b", bus.pc_hold, !FWD); end
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        checks = checks + 5;
        if (bus.pc_hold !== 1'b0) begin errors++; $display("FAIL reset_mid_stall pc_hold: got %b required 0", bus.pc_hold); end
        if (bus.id_bubble !== 1'b0) begin errors++; $display("FAIL reset_mid_stall id_bubble: got %b required 0", bus.id_bubble); end
        if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_mid_stall stall_cnt: got %0d required 0", bus.stall_cnt); end
        if (bus.fwd_a_sel !== 2'b00) begin errors++; $display("FAIL reset_mid_stall fwd_a_sel: got %b required 00", bus.fwd_a_sel); end
        if (bus.fwd_b_sel !== 2'b00) begin errors++; $display("FAIL reset_mid_stall fwd_b_sel: got %b required 00", bus.fwd_b_sel); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.pc_hold !== 1'b0) begin errors++; $display("FAIL reset_mid_stall after_release: got %b required 0", bus.pc_hold); end
        @(posedge clk);
        #1;
        bus.dec_valid = 1'b0;
        @(negedge clk);
        scen = "resume_after_reset";
        drive_instr(5'd9, 5'd6, 5'd1, 1'b1, 1'b1, 1'b0, st(3, 0), sel(2'b01), 2'b00);
        idle(4);
    endtask

    task automatic test_saturate();
        scen = "saturate";
        force dut.stall_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.stall_cnt_q;
        #1;
        exp_cnt = 65535;
        checks++;
        if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL saturate preset: got %h required ffff", bus.stall_cnt); end
        @(negedge clk);
        drive_instr(5'd5, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 0, 2'b00, 2'b00);
        drive_instr(5'd6, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, st(3, 1), 2'b00, sel(2'b10));
        idle(4);
        checks++;
        if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL saturate held: got %h required ffff", bus.stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_invalid_decode();
        test_raw_pair();
        test_load_use();
        test_wb_distance();
        test_use_rb();
        test_same_src();
        test_reg_zero();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturate();
        idle(2);
        scen = "final";
        checks = checks + 2;
        if (bubble_bad != 0) begin errors++; $display("FAIL final id_bubble_vs_pc_hold: got %0d disagreeing cycles required 0", bubble_bad); end
        if (exp_q.size() != 0) begin errors++; $display("FAIL final pending_expectations: got %0d required 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
